// File: rtl/fip_pkg.sv
// Shared Q16.16 fixed-point types, limits and arithmetic helpers for the
// ray-triangle datapath.
package fip_pkg;

    typedef logic signed [31:0] fip32_t;

    localparam fip32_t FIP_MIN      = 32'sh8000_0000;
    localparam fip32_t FIP_MAX      = 32'sh7FFF_FFFF;
    localparam int unsigned FIP_FRA_BITS = 16;

    // Negation that maps the most negative value to the most positive one.
    function automatic fip32_t neg_sat(input fip32_t x);
        if (x == FIP_MIN) begin
            return FIP_MAX;
        end
        return -x;
    endfunction

    // 33-bit sum clamped back into the 32-bit range.
    function automatic fip32_t add_sat(input fip32_t x, input fip32_t y);
        logic signed [32:0] s;
        s = {x[31], x} + {y[31], y};
        if (s[32] != s[31]) begin
            return s[32] ? FIP_MIN : FIP_MAX;
        end
        return s[31:0];
    endfunction

    function automatic fip32_t sub_sat(input fip32_t x, input fip32_t y);
        return add_sat(x, neg_sat(y));
    endfunction

    // Full-precision product rescaled by the fractional width; the upper bits
    // are dropped, so overflow wraps.
    function automatic fip32_t mult(input fip32_t x, input fip32_t y,
                                    input int unsigned fra);
        logic signed [63:0] p;
        p = 64'(x) * 64'(y);
        return fip32_t'(p >>> fra);
    endfunction

endpackage

// File: rtl/fip_32_mult.sv
// Combinational fixed-point multiplier, wrapping on overflow.
module fip_32_mult
    import fip_pkg::*;
#(
    parameter int unsigned FRA_BITS = FIP_FRA_BITS
) (
    input  fip32_t x_i,
    input  fip32_t y_i,
    output fip32_t p_o
);

    assign p_o = mult(x_i, y_i, FRA_BITS);

endmodule

// File: rtl/fip_32_3b3_det.sv
// Three-stage pipelined 3x3 determinant in signed fixed point. Accepts one
// matrix per clock; result and its valid flag appear three clocks later.
module fip_32_3b3_det
    import fip_pkg::*;
#(
    parameter int unsigned FRA_BITS = FIP_FRA_BITS
) (
    input  logic   i_clk,
    input  logic   i_rstn,
    input  logic   i_en,
    input  fip32_t i_array [0:2][0:2],
    output fip32_t o_det,
    output logic   o_valid
);

    // ---------------- stage 1: six minor products ----------------
    fip32_t ei_d, fh_d, di_d, fg_d, dh_d, eg_d;
    fip32_t ei_p1_q, fh_p1_q, di_p1_q, fg_p1_q, dh_p1_q, eg_p1_q;
    fip32_t a_p1_q, b_p1_q, c_p1_q;

    fip_32_mult #(.FRA_BITS(FRA_BITS)) u_mul_ei (.x_i(i_array[1][1]), .y_i(i_array[2][2]), .p_o(ei_d));
    fip_32_mult #(.FRA_BITS(FRA_BITS)) u_mul_fh (.x_i(i_array[1][2]), .y_i(i_array[2][1]), .p_o(fh_d));
    fip_32_mult #(.FRA_BITS(FRA_BITS)) u_mul_di (.x_i(i_array[1][0]), .y_i(i_array[2][2]), .p_o(di_d));
    fip_32_mult #(.FRA_BITS(FRA_BITS)) u_mul_fg (.x_i(i_array[1][2]), .y_i(i_array[2][0]), .p_o(fg_d));
    fip_32_mult #(.FRA_BITS(FRA_BITS)) u_mul_dh (.x_i(i_array[1][0]), .y_i(i_array[2][1]), .p_o(dh_d));
    fip_32_mult #(.FRA_BITS(FRA_BITS)) u_mul_eg (.x_i(i_array[1][1]), .y_i(i_array[2][0]), .p_o(eg_d));

    // Register the minor products and delay the top row to line up with them.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            ei_p1_q <= '0;
            fh_p1_q <= '0;
            di_p1_q <= '0;
            fg_p1_q <= '0;
            dh_p1_q <= '0;
            eg_p1_q <= '0;
            a_p1_q  <= '0;
            b_p1_q  <= '0;
            c_p1_q  <= '0;
        end else begin
            ei_p1_q <= ei_d;
            fh_p1_q <= fh_d;
            di_p1_q <= di_d;
            fg_p1_q <= fg_d;
            dh_p1_q <= dh_d;
            eg_p1_q <= eg_d;
            a_p1_q  <= i_array[0][0];
            b_p1_q  <= i_array[0][1];
            c_p1_q  <= i_array[0][2];
        end
    end

    // ---------------- stage 2: 2x2 minors and cofactor terms ----------------
    fip32_t m0_d, m1_d, m2_d;
    fip32_t t0_d, t1_d, t2_d;
    fip32_t t0_p2_q, t1_p2_q, t2_p2_q;

    assign m0_d = sub_sat(ei_p1_q, fh_p1_q);
    assign m1_d = sub_sat(di_p1_q, fg_p1_q);
    assign m2_d = sub_sat(dh_p1_q, eg_p1_q);

    fip_32_mult #(.FRA_BITS(FRA_BITS)) u_mul_t0 (.x_i(a_p1_q), .y_i(m0_d), .p_o(t0_d));
    fip_32_mult #(.FRA_BITS(FRA_BITS)) u_mul_t1 (.x_i(b_p1_q), .y_i(m1_d), .p_o(t1_d));
    fip_32_mult #(.FRA_BITS(FRA_BITS)) u_mul_t2 (.x_i(c_p1_q), .y_i(m2_d), .p_o(t2_d));

    // Register the three cofactor-weighted terms.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            t0_p2_q <= '0;
            t1_p2_q <= '0;
            t2_p2_q <= '0;
        end else begin
            t0_p2_q <= t0_d;
            t1_p2_q <= t1_d;
            t2_p2_q <= t2_d;
        end
    end

    // ---------------- stage 3: final signed sum ----------------
    fip32_t det_d;
    fip32_t det_p3_q;

    assign det_d = add_sat(sub_sat(t0_p2_q, t1_p2_q), t2_p2_q);

    // Output register for the determinant.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            det_p3_q <= '0;
        end else begin
            det_p3_q <= det_d;
        end
    end

    // Valid flag travels alongside the data; it is the only output qualifier.
    logic [2:0] vld_q;

    // Shift i_en through one bit per pipeline stage.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            vld_q <= '0;
        end else begin
            vld_q <= {vld_q[1:0], i_en};
        end
    end

    assign o_det   = det_p3_q;
    assign o_valid = vld_q[2];

endmodule

// File: tb/tb_fip_32_3b3_det.sv
// Bench for the pipelined 3x3 fixed-point determinant.
module tb_fip_32_3b3_det;

    typedef logic signed [31:0] w_t;

    typedef struct {
        string name;
        w_t    m [9];
        w_t    exp;
    } vec_t;

    typedef struct {
        logic  en;
        w_t    det;
        string name;
    } exp_t;

    localparam longint LMAX = 64'sd2147483647;
    localparam longint LMIN = -64'sd2147483648;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    logic en   = 1'b0;
    w_t   arr [0:2][0:2];
    w_t   det;
    logic valid;

    exp_t sb [$];
    int   n_cmp = 0;
    int   n_bad = 0;

    vec_t vecs [4];
    w_t   rm [9];
    w_t   zm [9];

    always #5 clk = ~clk;

    fip_32_3b3_det #(.FRA_BITS(16)) dut (
        .i_clk   (clk),
        .i_rstn  (rstn),
        .i_en    (en),
        .i_array (arr),
        .o_det   (det),
        .o_valid (valid)
    );

    function automatic w_t q(input int v);
        return w_t'(v * 65536);
    endfunction

    function automatic w_t r_mul(input w_t x, input w_t y);
        longint p;
        p = longint'(x) * longint'(y);
        p = p >>> 16;
        return w_t'(p);
    endfunction

    function automatic w_t r_add(input w_t x, input w_t y);
        longint s;
        s = longint'(x) + longint'(y);
        if (s > LMAX) return 32'sh7FFF_FFFF;
        if (s < LMIN) return 32'sh8000_0000;
        return w_t'(s);
    endfunction

    function automatic w_t r_sub(input w_t x, input w_t y);
        w_t ny;
        ny = (y == 32'sh8000_0000) ? 32'sh7FFF_FFFF : -y;
        return r_add(x, ny);
    endfunction

    // a b c / d e f / g h i  ->  m[0..8]
    function automatic w_t model_det(input w_t m [9]);
        w_t m0, m1, m2;
        m0 = r_sub(r_mul(m[4], m[8]), r_mul(m[5], m[7]));
        m1 = r_sub(r_mul(m[3], m[8]), r_mul(m[5], m[6]));
        m2 = r_sub(r_mul(m[3], m[7]), r_mul(m[4], m[6]));
        return r_add(r_sub(r_mul(m[0], m0), r_mul(m[1], m1)), r_mul(m[2], m2));
    endfunction

    task automatic check_out(input exp_t e);
        n_cmp++;
        if (valid !== e.en) begin
            n_bad++;
            $display("FAIL %s o_valid: got %b, required %b", e.name, valid, e.en);
        end
        if (e.en) begin
            n_cmp++;
            if (det !== e.det) begin
                n_bad++;
                $display("FAIL %s o_det: got %0d (0x%08h), required %0d (0x%08h)",
                         e.name, det, det, e.det, e.det);
            end
        end
    endtask

    // Drive one matrix, push its expectation, clock once and retire the
    // entry whose result is now on the outputs.
    task automatic step(input logic e_in, input w_t m [9], input w_t exp, input string nm);
        exp_t e;
        en = e_in;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                arr[r][c] = m[r*3 + c];
        e.en   = e_in;
        e.det  = exp;
        e.name = nm;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() >= 3) check_out(sb.pop_front());
    endtask

    task automatic prefill_idle(input string nm);
        exp_t e;
        e.en   = 1'b0;
        e.det  = '0;
        e.name = nm;
        sb.push_back(e);
        sb.push_back(e);
    endtask

    task automatic check_reset(input string nm);
        n_cmp++;
        if (valid !== 1'b0) begin
            n_bad++;
            $display("FAIL %s o_valid: got %b, required 0", nm, valid);
        end
        n_cmp++;
        if (det !== 32'sd0) begin
            n_bad++;
            $display("FAIL %s o_det: got 0x%08h, required 0x00000000", nm, det);
        end
    endtask

    initial begin
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                arr[r][c] = '0;
        for (int j = 0; j < 9; j++) zm[j] = '0;

        vecs[0].name = "identity";
        vecs[0].m    = '{q(1), 0, 0, 0, q(1), 0, 0, 0, q(1)};
        vecs[0].exp  = 32'sd65536;
        vecs[1].name = "singular123";
        vecs[1].m    = '{q(1), q(2), q(3), q(4), q(5), q(6), q(7), q(8), q(9)};
        vecs[1].exp  = 32'sd0;
        vecs[2].name = "neg18";
        vecs[2].m    = '{q(1), q(-1), q(3), q(4), q(5), q(6), q(7), q(8), q(9)};
        vecs[2].exp  = -32'sd1179648;
        vecs[3].name = "minor_sat";
        vecs[3].m    = '{q(1), 0, 0, 0, q(128), q(128), 0, q(-128), q(128)};
        vecs[3].exp  = 32'sh7FFF_FFFF;

        // Reset held from time 0, outputs must be zero before and after edges.
        #12;
        check_reset("reset_initial");
        #20;
        check_reset("reset_held");
        rstn = 1'b1;
        prefill_idle("post_reset");

        // Directed table, back-to-back.
        for (int k = 0; k < 4; k++)
            step(1'b1, vecs[k].m, vecs[k].exp, vecs[k].name);

        // Single bubble between two valid inputs.
        step(1'b1, vecs[0].m, vecs[0].exp, "bubble_pre");
        for (int j = 0; j < 9; j++) rm[j] = w_t'($urandom());
        step(1'b0, rm, '0, "bubble");
        step(1'b1, vecs[2].m, vecs[2].exp, "bubble_post");

        // Random matrices: small-range and full-range, occasional bubbles.
        for (int k = 0; k < 48; k++) begin
            for (int j = 0; j < 9; j++) begin
                if (k % 2 == 0)
                    rm[j] = w_t'(int'($urandom_range(0, 2621440)) - 1310720);
                else
                    rm[j] = w_t'($urandom());
            end
            step($urandom_range(0, 4) != 0, rm, model_det(rm),
                 (k % 2 == 0) ? "rand_small" : "rand_full");
        end

        // Back-to-back stream, then reset while results are in flight.
        step(1'b1, vecs[0].m, vecs[0].exp, "stream_id");
        step(1'b1, vecs[1].m, vecs[1].exp, "stream_sing");
        step(1'b1, vecs[2].m, vecs[2].exp, "stream_neg");
        rstn = 1'b0;
        en   = 1'b0;
        #1;
        check_reset("reset_midstream");
        sb.delete();
        #3;
        rstn = 1'b1;
        prefill_idle("flushed");
        step(1'b1, vecs[0].m, vecs[0].exp, "after_reset_id");
        step(1'b0, zm, '0, "after_reset_idle0");
        step(1'b0, zm, '0, "after_reset_idle1");
        step(1'b1, vecs[3].m, vecs[3].exp, "after_reset_sat");

        // Drain the pipeline.
        for (int k = 0; k < 3; k++) step(1'b0, zm, '0, "drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
